serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//   Bit-serial sequencer for the single-bit fullsubtractor cell. Latches two
//   WIDTH-bit operands plus a borrow-in, then presents one bit pair per cycle
//   (LSB first) to the shared cell and chains its borrow into the next bit.
//   Assembles the WIDTH-bit difference and final borrow, then hands back with done.
//   Sits between a requesting datapath and one instantiated fullsubtractor.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request; sampled only while ready=1
//   a        in   WIDTH  minuend, captured on accepted start
//   b        in   WIDTH  subtrahend, captured on accepted start
//   bin      in   1      borrow-in, captured on accepted start
//   ready    out  1      controller idle, start will be accepted
//   busy     out  1      serial subtraction in progress
//   done     out  1      one-cycle pulse: diff/bout valid
//   diff     out  WIDTH  a - b - bin mod 2^WIDTH; held until next accepted start
//   bout     out  1      final borrow (1 = a < b + bin unsigned); held likewise
//   fs_a     out  1      to cell Ain: current minuend bit
//   fs_b     out  1      to cell Bin: current subtrahend bit
//   fs_bin   out  1      to cell Cin: running borrow
//   fs_d     in   1      from cell: difference = Ain^Bin^Cin
//   fs_bo    in   1      from cell: borrow = (~Ain&Bin)|(~(Ain^Bin)&Cin)
// BEHAVIOUR
//   Clock/reset: one clock domain; rst_n clears all flops asynchronously, release synchronous to clk.
//   Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0,
//     fs_a=fs_b=fs_bin=0, internal shift regs/borrow/bit counter = 0.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: ready=1. On clk edge with start=1: a_sh<=a, b_sh<=b, brw<=bin,
//     cnt<=0, -> RUN. start=0: stay.
//   RUN: busy=1, ready=0. fs_a=a_sh[0], fs_b=b_sh[0], fs_bin=brw (from flops,
//     so cell is combinational in same cycle). Each edge: a_sh,b_sh >>1;
//     d_sh <= {fs_d, d_sh[WIDTH-1:1]}; brw<=fs_bo; cnt<=cnt+1.
//     When cnt==WIDTH-1 at the edge: diff<={fs_d,d_sh[WIDTH-1:1]}, bout<=fs_bo, -> DONE.
//   DONE: done=1 exactly one cycle, busy=0, ready=0; unconditionally -> IDLE.
//   fs_* outputs are 0 outside RUN.
//   Latency: start accepted at edge T; RUN occupies WIDTH cycles; done high in
//     cycle following edge T+WIDTH; next start accepted at edge T+WIDTH+2.
//   start while busy or in DONE: ignored, no queuing; a/b/bin changes ignored
//     after capture.
//   diff/bout update only on the RUN->DONE edge; stable otherwise.
//   Arithmetic: unsigned mod 2^WIDTH; cnt is $clog2(WIDTH) bits, never wraps
//     beyond WIDTH-1.
//   Reset mid-RUN or in DONE: immediate return to reset values; no done pulse,
//     partial result discarded, diff/bout cleared.
//   fs_d/fs_bo are sampled only in RUN; X on them outside RUN is harmless.
// TESTING (bench instantiates fullsubtractor wired to fs_* ports, WIDTH=8)
//   a=8'h05,b=8'h03,bin=0, start 1 cycle -> busy 8 cycles, done pulse, diff=8'h02, bout=0
//   a=8'h00,b=8'h01,bin=0 -> diff=8'hFF, bout=1; a=8'h3C,b=8'h3C,bin=1 -> diff=8'hFF, bout=1
//   a=8'hFF,b=8'h00,bin=1 -> diff=8'hFE, bout=0; check fs_bin follows borrow chain bit by bit
//   start pulsed with new operands at RUN cycle 3 and in DONE -> ignored, first result unchanged
//   rst_n low at RUN cycle 4 -> ready=1, busy=0, diff=0, bout=0, no done; then clean op passes
//   start held high continuously -> ops back-to-back every WIDTH+2 cycles, each result correct

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial sequencer for an external single-bit full subtractor cell
// Feeds one operand bit pair per cycle LSB first, chaining the cell's borrow into the next bit.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             in_run;
  logic [WIDTH-1:0] res_d;

  assign in_run = (state_q == RUN);
  assign res_d  = {fs_d, res_sh_q[WIDTH-1:1]};

  // The cell is combinational, so its result for the bit on the flops is sampled this edge.
  assign fs_a   = in_run & a_sh_q[0];
  assign fs_b   = in_run & b_sh_q[0];
  assign fs_bin = in_run & brw_q;

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_d;
          brw_q    <= fs_bo;
          if (cnt_q == CNT_LAST) begin
            diff_q  <= res_d;
            bout_q  <= fs_bo;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl with a behavioural subtractor cell
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, busy, done, bout;
  logic [W-1:0] diff;
  logic         fs_a, fs_b, fs_bin, fs_d, fs_bo;

  always #5 clk = ~clk;

  assign fs_d  = fs_a ^ fs_b ^ fs_bin;
  assign fs_bo = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout),
    .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bo(fs_bo)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    int           acc;
  } op_t;

  op_t          q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [W-1:0] hold_diff = '0;
  logic         hold_bout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer subtraction; negative result means a borrow out.
  function automatic logic [W:0] model(input op_t o);
    int r;
    r = int'(o.a) - int'(o.b) - int'(o.bin);
    return {r < 0, W'(r)};
  endfunction

  function automatic logic borrow_into(input op_t o, input int k);
    int m;
    m = (1 << k) - 1;
    return (int'(o.a) & m) < ((int'(o.b) & m) + int'(o.bin));
  endfunction

  always @(negedge clk) begin : monitor
    op_t          o;
    logic [W:0]   e;
    if (!rst_n) begin
      busy_cnt  = 0;
      hold_diff = '0;
      hold_bout = 1'b0;
    end else begin
      if (busy) begin
        if (q.size() == 0 || busy_cnt >= W) begin
          chk("busy_unexpected", 32'd1, 32'd0);
        end else begin
          o = q[0];
          chk("fs_a", 32'(fs_a), 32'(o.a[busy_cnt]));
          chk("fs_b", 32'(fs_b), 32'(o.b[busy_cnt]));
          chk("fs_bin", 32'(fs_bin), 32'(borrow_into(o, busy_cnt)));
        end
        busy_cnt++;
      end else begin
        chk("fs_idle_zero", 32'({fs_a, fs_b, fs_bin}), 32'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          o = q.pop_front();
          e = model(o);
          chk("diff", 32'(diff), 32'(e[W-1:0]));
          chk("bout", 32'(bout), 32'(e[W]));
          chk("latency", 32'(cyc - o.acc), 32'(W + 1));
          chk("busy_cycles", 32'(busy_cnt), 32'(W));
          chk("ready_in_done", 32'(ready), 32'd0);
          hold_diff = e[W-1:0];
          hold_bout = e[W];
        end
        busy_cnt = 0;
      end else begin
        chk("diff_hold", 32'(diff), 32'(hold_diff));
        chk("bout_hold", 32'(bout), 32'(hold_bout));
      end
    end
  end

  task automatic push_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
    op_t o;
    o.a = ai; o.b = bi; o.bin = bini; o.acc = cyc;
    q.push_back(o);
  endtask

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      a = ai; b = bi; bin = bini; start = 1'b1;
      push_op(ai, bi, bini);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_fs", 32'({fs_a, fs_b, fs_bin}), 32'd0);
  endtask

  initial begin : driver
    int n;
    int prev;
    int got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #2 rst_n = 1'b1;

    issue(8'h05, 8'h03, 1'b0);
    issue(8'h00, 8'h01, 1'b0);
    issue(8'h3C, 8'h3C, 1'b1);
    issue(8'hFF, 8'h00, 1'b1);

    // Starts during RUN cycle 3 and during the done pulse must be dropped.
    issue(8'h9A, 8'h27, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'hEE; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    start = 1'b1; a = 8'h22; b = 8'hDD; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in RUN cycle 4 discards the operation.
    issue(8'h77, 8'h12, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals();
    q.delete();
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    issue(8'h40, 8'h41, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Start held high: accepts every W+2 cycles.
    n = 0; got = 0; prev = 0;
    start = 1'b1;
    while (got < 6 && n < 200) begin
      @(negedge clk);
      n++;
      if (ready) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        push_op(a, b, bin);
        if (got > 0) chk("b2b_interval", 32'(cyc - prev), 32'(W + 2));
        prev = cyc;
        got++;
      end else begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
    end
    chk("b2b_count", 32'(got), 32'd6);
    @(negedge clk);
    start = 1'b0;

    n = 0;
    while ((q.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
